// File: rtl/bullet_draw_controller.sv
// rtl/bullet_draw_controller.sv - frame-paced draw/erase/step sequencer for the bullet handler
// Walks a BULLET_W x BULLET_H pixel block per pass and steps the handler once per frame tick.
module bullet_draw_controller #(
  parameter int          BULLET_W      = 2,
  parameter int          BULLET_H      = 4,
  parameter int          FRAME_DIV     = 833333,
  parameter logic [2:0]  BULLET_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fire,
  input  logic [7:0] bulletX,
  input  logic [6:0] bulletY,
  input  logic       reachtop,
  input  logic       active,
  output logic       resetb_out,
  output logic       updateb_out,
  output logic       waitb_out,
  output logic [7:0] plotX,
  output logic [6:0] plotY,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int FW = $clog2(FRAME_DIV);
  localparam int CW = (BULLET_W > 1) ? $clog2(BULLET_W) : 1;
  localparam int RW = (BULLET_H > 1) ? $clog2(BULLET_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_UPDATE,
    S_SETTLE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [FW-1:0]  r_frame_cnt;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic           w_tick;
  logic           w_walk;
  logic           w_col_last;
  logic           w_last;

  assign w_tick     = (r_frame_cnt == FW'(FRAME_DIV - 1));
  assign w_walk     = (r_state == S_DRAW) || (r_state == S_ERASE);
  assign w_col_last = (r_col == CW'(BULLET_W - 1));
  assign w_last     = w_col_last && (r_row == RW'(BULLET_H - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + FW'(1);
    end
  end

  // Counter idles at zero and wraps on the last pixel, so every DRAW/ERASE entry starts at (0,0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (!w_walk) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_col_last) begin
      r_col <= '0;
      r_row <= w_last ? '0 : r_row + RW'(1);
    end else begin
      r_col <= r_col + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    resetb_out  = 1'b0;
    updateb_out = 1'b0;
    waitb_out   = 1'b0;
    plot        = 1'b0;
    colour      = 3'b000;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        resetb_out = 1'b1;
        busy       = 1'b0;
        if (fire) w_next = S_DRAW;
      end
      S_DRAW: begin
        plot   = 1'b1;
        colour = BULLET_COLOUR;
        if (w_last) w_next = S_WAIT;
      end
      S_WAIT: begin
        waitb_out = 1'b1;
        if (w_tick) w_next = S_ERASE;
      end
      S_ERASE: begin
        plot   = 1'b1;
        colour = BG_COLOUR;
        if (w_last) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        updateb_out = 1'b1;
        w_next      = S_SETTLE;
      end
      S_SETTLE: begin
        if (reachtop || !active) w_next = S_IDLE;
        else                     w_next = S_DRAW;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign plotX = plot ? (bulletX + 8'(r_col)) : 8'd0;
  assign plotY = plot ? (bulletY + 7'(r_row)) : 7'd0;

endmodule

// File: tb/tb_bullet_draw_controller.sv
// tb/tb_bullet_draw_controller.sv - scoreboard bench for bullet_draw_controller
// Expected pixel writes are queued by the stimulus; a negedge monitor pops and compares them.
module tb_bullet_draw_controller;

  logic       clk = 1'b0;
  logic       resetn;
  logic       fire;
  logic [7:0] bulletX;
  logic [6:0] bulletY;
  logic       reachtop;
  logic       active;
  logic       resetb_out;
  logic       updateb_out;
  logic       waitb_out;
  logic [7:0] plotX;
  logic [6:0] plotY;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  int cyc      = 0;
  int last_tick_cyc = -100;
  logic prev_wait = 1'b0;
  logic prev_tick = 1'b0;
  logic prev_upd  = 1'b0;

  logic [17:0] exp_q[$];
  logic [17:0] exp_e;

  logic [6:0] hy;
  logic       hreach;
  logic       kill;
  logic [3:0] tb_fc;

  always #5 clk = ~clk;

  bullet_draw_controller #(
    .BULLET_W(2), .BULLET_H(4), .FRAME_DIV(16),
    .BULLET_COLOUR(3'b111), .BG_COLOUR(3'b000)
  ) dut (
    .clk(clk), .resetn(resetn), .fire(fire),
    .bulletX(bulletX), .bulletY(bulletY), .reachtop(reachtop), .active(active),
    .resetb_out(resetb_out), .updateb_out(updateb_out), .waitb_out(waitb_out),
    .plotX(plotX), .plotY(plotY), .colour(colour), .plot(plot), .busy(busy)
  );

  // Behavioural handler: starts at Y=99, steps -6 while y>8, else raises reachtop.
  always @(posedge clk) begin
    if (resetb_out) begin
      hy     <= 7'd99;
      hreach <= 1'b0;
    end else if (updateb_out) begin
      if (hy > 7'd8) hy <= hy - 7'd6;
      else           hreach <= 1'b1;
    end
  end
  assign bulletY  = hy;
  assign reachtop = hreach;
  assign active   = !hreach && !kill;

  // Frame tick reference: 16-cycle free-running count cleared by reset.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)            tb_fc <= 4'd0;
    else if (tb_fc == 4'd15) tb_fc <= 4'd0;
    else                    tb_fc <= tb_fc + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_pass(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    logic [7:0] px;
    logic [6:0] py;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 2; k++) begin
        px = x + 8'(k);
        py = y + 7'(r);
        exp_q.push_back({px, py, c});
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (prev_wait) check("wait_exit", {31'd0, waitb_out}, {31'd0, !prev_tick});
    if (prev_upd)  check("settle_cycle", {resetb_out, updateb_out, waitb_out, plot, busy}, 5'b00001);
    if (waitb_out && tb_fc == 4'd15) last_tick_cyc = cyc;
    if (updateb_out) begin
      check("upd_latency", cyc - last_tick_cyc, 9);
      upd_cnt++;
    end
    if (plot) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel actual=%0h required=none at %0t", {plotX, plotY, colour}, $time);
      end else begin
        exp_e = exp_q.pop_front();
        check("pixel", {plotX, plotY, colour}, exp_e);
      end
    end
    prev_wait = waitb_out && resetn;
    prev_tick = (tb_fc == 4'd15);
    prev_upd  = updateb_out;
  end

  initial begin
    int bad;
    resetn  = 1'b0;
    fire    = 1'b0;
    kill    = 1'b0;
    bulletX = 8'd50;
    repeat (3) @(negedge clk);
    check("reset_strobes", {resetb_out, updateb_out, waitb_out, plot, busy}, 5'b10000);
    check("reset_pixel", {plotX, plotY, colour}, 18'd0);
    resetn = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || plot || !resetb_out) bad++;
    end
    check("idle_hold", bad, 0);

    // Full flight: 17 draw/erase passes from Y=99 down to Y=3.
    for (int p = 0; p < 17; p++) begin
      push_pass(8'd50, 7'(99 - 6 * p), 3'd7);
      push_pass(8'd50, 7'(99 - 6 * p), 3'd0);
    end
    upd_cnt = 0;
    @(negedge clk) fire = 1'b1;
    @(negedge clk) fire = 1'b0;
    check("draw_start", {busy, plot, colour}, {1'b1, 1'b1, 3'd7});
    repeat (3) @(negedge clk);
    fire = 1'b1;
    @(negedge clk) fire = 1'b0;
    repeat (4) @(negedge clk);
    check("wait_after_draw", {waitb_out, plot}, 2'b10);
    fire = 1'b1;
    @(negedge clk) fire = 1'b0;
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("flight_done", {31'd0, busy}, 0);
    check("upd_count", upd_cnt, 17);
    check("flight_queue", exp_q.size(), 0);

    // Back-to-back launch with active=0 ending each flight after one step.
    bulletX = 8'd20;
    kill    = 1'b1;
    push_pass(8'd20, 7'd99, 3'd7);
    push_pass(8'd20, 7'd99, 3'd0);
    push_pass(8'd20, 7'd99, 3'd7);
    push_pass(8'd20, 7'd99, 3'd0);
    @(negedge clk) fire = 1'b1;
    for (int i = 0; i < 200 && !updateb_out; i++) @(negedge clk);
    check("b2b_upd", {31'd0, updateb_out}, 1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_idle", {resetb_out, busy, plot}, 3'b100);
    @(negedge clk);
    check("b2b_redraw", {busy, plot}, 2'b11);
    fire = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("b2b_done", {31'd0, busy}, 0);
    check("b2b_queue", exp_q.size(), 0);
    kill = 1'b0;

    // Asynchronous reset in the middle of ERASE.
    bulletX = 8'd60;
    @(negedge clk);
    push_pass(8'd60, 7'd99, 3'd7);
    exp_q.push_back({8'd60, 7'd99, 3'd0});
    @(negedge clk) fire = 1'b1;
    @(negedge clk) fire = 1'b0;
    for (int i = 0; i < 200 && !(plot && colour == 3'd0); i++) @(negedge clk);
    check("erase_seen", {plot, colour}, 4'b1000);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 check("abort_outputs", {plot, resetb_out, busy, updateb_out, waitb_out}, 5'b01000);
    @(negedge clk);
    @(negedge clk) resetn = 1'b1;
    check("abort_queue", exp_q.size(), 0);

    // X wrap: 255 then 0.
    bulletX = 8'd255;
    kill    = 1'b1;
    @(negedge clk);
    push_pass(8'd255, 7'd99, 3'd7);
    push_pass(8'd255, 7'd99, 3'd0);
    @(negedge clk) fire = 1'b1;
    @(negedge clk) fire = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("wrap_done", {31'd0, busy}, 0);
    check("wrap_queue", exp_q.size(), 0);
    check("idle_pixel", {plotX, plotY, colour}, 18'd0);
    kill = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bullet_draw_controller.md
Name: bullet_draw_controller

Overview:
- Frame-paced initiator FSM for the bullet position handler.
- Drives the handler's reset, update and wait strobes, and reads back bulletX/bulletY/reachtop/active.
- Emits one-pixel-per-cycle plot writes to the VGA adapter: draws the bullet, holds it for one frame, erases it, steps it, and repeats until the bullet reaches the top.
- Sits between the game top-level (fire button, frame timing) and the VGA adapter.

Parameters:
- BULLET_W, 2: bullet width in pixels (1-8).
- BULLET_H, 4: bullet height in pixels (1-8).
- FRAME_DIV, 833333: clk cycles per frame tick (60 Hz at 50 MHz); must be at least 2.
- BULLET_COLOUR, 3'b111: draw colour.
- BG_COLOUR, 3'b000: erase colour.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- fire  in  1  launch request, level or pulse, sampled in IDLE only.
- bulletX  in  8  bullet X from the handler.
- bulletY  in  7  bullet Y from the handler.
- reachtop  in  1  handler top-reached flag.
- active  in  1  handler active flag.
- resetb_out  out  1  handler reset strobe (handler tracks player X while high).
- updateb_out  out  1  handler one-step update strobe.
- waitb_out  out  1  handler wait strobe.
- plotX  out  8  pixel X to the VGA adapter.
- plotY  out  7  pixel Y to the VGA adapter.
- colour  out  3  pixel colour.
- plot  out  1  pixel write enable.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: resetn low forces state IDLE, the pixel counter to 0 and the frame counter to 0, asynchronously.
  - While in reset: resetb_out=1; updateb_out, waitb_out, plot and busy are 0; plotX, plotY and colour are 0.
- Strobes and plot are Moore-decoded from state, with no registered lag.
- Frame counter:
  - Free-running 0..FRAME_DIV-1; tick is high for the cycle where count==FRAME_DIV-1, then the counter wraps to 0.
  - Runs in every state.
  - A tick outside WAIT is discarded, not queued.
- Pixel counter:
  - Registered col (0..BULLET_W-1) and row (0..BULLET_H-1); col increments first.
  - Cleared on entry to DRAW and on entry to ERASE.
  - plotX = bulletX+col, truncated to 8 bits (wraps).
  - plotY = bulletY+row, truncated to 7 bits (wraps).
  - plotX and plotY are combinational from the counter and inputs, and valid only while plot=1.
- States:
  - IDLE: resetb_out=1, busy=0. If fire=1, go to DRAW next cycle.
  - DRAW: plot=1, colour=BULLET_COLOUR, one pixel per cycle. After exactly BULLET_W*BULLET_H cycles (last pixel col=W-1, row=H-1), go to WAIT.
  - WAIT: waitb_out=1. On tick, go to ERASE. A WAIT state that begins on a tick cycle leaves on that cycle.
  - ERASE: same pixel walk as DRAW, with colour=BG_COLOUR. Go to UPDATE after BULLET_W*BULLET_H cycles.
  - UPDATE: updateb_out=1 for exactly one cycle, then SETTLE.
  - SETTLE: all strobes 0. Handler outputs are registered, so new values are visible here.
    - If reachtop=1 or active=0, go to IDLE.
    - Otherwise go to DRAW.
- fire while busy=1 is ignored.
- Back-to-back launch: fire held high while returning from SETTLE to IDLE gives one IDLE cycle with resetb_out=1, then DRAW.
- Timing:
  - Per-frame overhead is 2*W*H+2 cycles plus the WAIT time.
  - Step latency is fixed: UPDATE is asserted W*H+1 cycles after the tick.
- Reset mid-operation (any state, including mid-pixel) returns to IDLE immediately. A partially drawn bullet is left on screen; erasing it is the top-level's job.

Test Plan:
- Reset and idle: hold resetn=0 with FRAME_DIV=16, then release.
  - Required: resetb_out=1, plot=0, busy=0, updateb_out=0, waitb_out=0.
  - With fire=0, the state stays IDLE for 100 cycles.
- Draw walk: fire pulse with bulletX=50, bulletY=99.
  - Required: the cycle after, plot=1 for exactly 8 consecutive cycles at (50,99),(51,99),(50,100),(51,100)…(51,102), all with colour 7.
  - Then waitb_out=1.
- Frame pacing: in WAIT, the tick arrives.
  - Required: 8 erase cycles at the same coordinates with colour 0.
  - Then exactly one updateb_out cycle, then one SETTLE cycle, then DRAW.
  - The bench checks no tick is lost and none is double-counted.
- Full flight: use a behavioural handler model (start at 99, step -6 while y>8, else reachtop).
  - Required: 17 draw passes at Y=99,93,…,9,3.
  - The 17th update raises reachtop, then IDLE; total updateb_out pulses = 17.
- Ignore and abort cases:
  - fire pulsed during DRAW and WAIT: no state change.
  - active=0 in SETTLE: goes to IDLE.
  - resetn pulsed low in the middle of ERASE: plot drops to 0 asynchronously and resetb_out goes to 1.
- Wrap: bulletX=255, BULLET_W=2.
  - Required: plotX sequence is 255,0 (8-bit wrap), with no X/Z values on the outputs.
